// File: rtl/seg_count_gen_pkg.sv
// seg_pkg: shared FSM encodings and 6-digit board defaults for the segment counter
package seg_pkg;
    typedef enum logic {
        ST_PAUSE = 1'b0,
        ST_RUN   = 1'b1
    } seg_state_t;
    localparam int DEF_TICK_DIV = 2_400_000;
    localparam int DEF_DATA_W   = 20;
    localparam int DEF_MAX_VAL  = 999_999;
    localparam int DEF_DIGITS   = 6;
endpackage

// File: rtl/seg_count_gen_tick_prescaler.sv
// tick_prescaler: divides sys_clk into a one-cycle step strobe every TICK_DIV enabled cycles
module tick_prescaler #(
    parameter int TICK_DIV = 2_400_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    logic [CW-1:0] r_cnt;
    assign tick_o = en_i && (r_cnt == LAST);
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            r_cnt <= '0;
        else if (clr_i || tick_o)
            r_cnt <= '0;
        else if (en_i)
            r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/seg_count_gen.sv
// seg_count_gen: run/pause display counter with load, clear, up/down, signed range and wrap/saturate
module seg_count_gen
    import seg_pkg::*;
#(
    parameter int               TICK_DIV   = DEF_TICK_DIV,
    parameter int               DATA_W     = DEF_DATA_W,
    parameter int               MAX_VAL    = DEF_MAX_VAL,
    parameter int               DIGITS     = DEF_DIGITS,
    parameter logic [DIGITS-1:0] POINT_MASK = '0,
    parameter bit               SIGNED_EN  = 1'b0,
    parameter bit               SATURATE   = 1'b0
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] load_val,
    input  logic              load_sign,
    input  logic              dir_down,
    output logic [DATA_W-1:0] data,
    output logic [DIGITS-1:0] point,
    output logic              en,
    output logic              sign,
    output logic              running,
    output logic              wrap_p
);
    localparam logic [DATA_W-1:0] MAXV = DATA_W'(MAX_VAL);
    seg_state_t        r_state;
    logic [DATA_W-1:0] r_data;
    logic [DIGITS-1:0] r_point;
    logic              r_en;
    logic              r_sign;
    logic              r_running;
    logic              r_wrap;
    logic              w_tick;
    logic              w_up;
    logic              w_grow;
    logic              w_lim;
    logic              w_nxt_sign;
    logic [DATA_W-1:0] w_nxt_data;
    logic [DATA_W-1:0] w_load_mag;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .en_i     (r_state == ST_RUN),
        .clr_i    (clear || load),
        .tick_o   (w_tick)
    );

    assign w_up       = !dir_down;
    assign w_load_mag = (load_val > MAXV) ? MAXV : load_val;

    // In sign-magnitude the step either grows or shrinks the magnitude; zero going down grows into -1.
    always_comb begin
        w_grow     = SIGNED_EN ? ((w_up && !r_sign) || (!w_up && (r_sign || r_data == '0))) : w_up;
        w_lim      = SIGNED_EN ? (w_grow && r_data == MAXV) : (w_up ? r_data == MAXV : r_data == '0);
        w_nxt_data = w_lim ? (SATURATE ? r_data : ((SIGNED_EN || !w_up) ? MAXV : '0))
                           : (w_grow ? r_data + 1'b1 : r_data - 1'b1);
        w_nxt_sign = !SIGNED_EN ? 1'b0
                   : w_lim      ? (SATURATE ? r_sign : w_up)
                   : w_grow     ? !w_up
                   : (r_data == DATA_W'(1)) ? 1'b0 : r_sign;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state   <= ST_PAUSE;
            r_running <= 1'b0;
            r_data    <= '0;
            r_sign    <= 1'b0;
            r_point   <= '0;
            r_en      <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            r_en    <= 1'b1;
            r_point <= POINT_MASK;
            r_wrap  <= 1'b0;
            if (stop) begin
                r_state   <= ST_PAUSE;
                r_running <= 1'b0;
            end else if (start) begin
                r_state   <= ST_RUN;
                r_running <= 1'b1;
            end
            if (clear) begin
                r_data <= '0;
                r_sign <= 1'b0;
            end else if (load) begin
                r_data <= w_load_mag;
                r_sign <= SIGNED_EN && load_sign && (w_load_mag != '0);
            end else if (w_tick) begin
                r_data <= w_nxt_data;
                r_sign <= w_nxt_sign;
                r_wrap <= w_lim;
            end
        end
    end

    assign data    = r_data;
    assign sign    = r_sign;
    assign point   = r_point;
    assign en      = r_en;
    assign running = r_running;
    assign wrap_p  = r_wrap;
endmodule

// File: tb/tb_seg_count_gen.sv
// tb_seg_count_gen: three counter variants (wrap, saturate, signed) on shared stimulus vs. an integer model
module tb_seg_count_gen;
    localparam int TD = 4;
    localparam int MX = 9;
    localparam logic [5:0] MASK = 6'b000100;

    typedef struct packed {
        logic [3:0] data;
        logic       sign;
        logic       wrap;
        logic       run;
        logic       en;
        logic [5:0] point;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, stop = 1'b0, clear = 1'b0, load = 1'b0, load_sign = 1'b0, dir_down = 1'b0;
    logic [3:0] load_val = '0;
    logic [3:0] data [3];
    logic [5:0] point [3];
    logic en [3], sign [3], running [3], wrap_p [3];

    int checks = 0;
    int failures = 0;
    int ncyc = 0;
    obs_t q[$];
    int m_val [3];
    bit m_wrap [3];
    int m_pre = 0;
    bit m_run = 1'b0;
    bit m_en = 1'b0;

    always #5 clk = ~clk;

    seg_count_gen #(.TICK_DIV(TD), .DATA_W(4), .MAX_VAL(MX), .DIGITS(6), .POINT_MASK(MASK),
                    .SIGNED_EN(1'b0), .SATURATE(1'b0)) u_wrap (
        .sys_clk(clk), .sys_rst_n(rst_n), .start(start), .stop(stop), .clear(clear), .load(load),
        .load_val(load_val), .load_sign(load_sign), .dir_down(dir_down), .data(data[0]),
        .point(point[0]), .en(en[0]), .sign(sign[0]), .running(running[0]), .wrap_p(wrap_p[0]));
    seg_count_gen #(.TICK_DIV(TD), .DATA_W(4), .MAX_VAL(MX), .DIGITS(6), .POINT_MASK(MASK),
                    .SIGNED_EN(1'b0), .SATURATE(1'b1)) u_sat (
        .sys_clk(clk), .sys_rst_n(rst_n), .start(start), .stop(stop), .clear(clear), .load(load),
        .load_val(load_val), .load_sign(load_sign), .dir_down(dir_down), .data(data[1]),
        .point(point[1]), .en(en[1]), .sign(sign[1]), .running(running[1]), .wrap_p(wrap_p[1]));
    seg_count_gen #(.TICK_DIV(TD), .DATA_W(4), .MAX_VAL(MX), .DIGITS(6), .POINT_MASK(MASK),
                    .SIGNED_EN(1'b1), .SATURATE(1'b0)) u_sgn (
        .sys_clk(clk), .sys_rst_n(rst_n), .start(start), .stop(stop), .clear(clear), .load(load),
        .load_val(load_val), .load_sign(load_sign), .dir_down(dir_down), .data(data[2]),
        .point(point[2]), .en(en[2]), .sign(sign[2]), .running(running[2]), .wrap_p(wrap_p[2]));

    function automatic bit is_sat(int i);
        return i == 1;
    endfunction

    function automatic bit is_sgn(int i);
        return i == 2;
    endfunction

    function automatic int stepv(int v, bit up, bit s, bit sa, output bit w);
        int lo;
        lo = s ? -MX : 0;
        w = 1'b0;
        if (up) begin
            if (v == MX) begin
                w = 1'b1;
                return sa ? v : lo;
            end
            return v + 1;
        end
        if (v == lo) begin
            w = 1'b1;
            return sa ? v : MX;
        end
        return v - 1;
    endfunction

    function automatic obs_t expect_of(int i);
        obs_t e;
        e.data  = 4'(m_val[i] < 0 ? -m_val[i] : m_val[i]);
        e.sign  = m_val[i] < 0;
        e.wrap  = m_wrap[i];
        e.run   = m_run;
        e.en    = m_en;
        e.point = m_en ? MASK : 6'b0;
        return e;
    endfunction

    function automatic obs_t obs_of(int i);
        obs_t o;
        o.data  = data[i];
        o.sign  = sign[i];
        o.wrap  = wrap_p[i];
        o.run   = running[i];
        o.en    = en[i];
        o.point = point[i];
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_val[i] = 0;
            m_wrap[i] = 1'b0;
        end
        m_pre = 0;
        m_run = 1'b0;
        m_en = 1'b0;
    endtask

    task automatic model_edge();
        bit stp;
        int mag;
        stp = m_run && (m_pre == TD - 1);
        for (int i = 0; i < 3; i++) begin
            m_wrap[i] = 1'b0;
            if (clear)
                m_val[i] = 0;
            else if (load) begin
                mag = (int'(load_val) > MX) ? MX : int'(load_val);
                m_val[i] = (is_sgn(i) && load_sign) ? -mag : mag;
            end else if (stp)
                m_val[i] = stepv(m_val[i], !dir_down, is_sgn(i), is_sat(i), m_wrap[i]);
        end
        if (clear || load || stp)
            m_pre = 0;
        else if (m_run)
            m_pre++;
        if (stop)
            m_run = 1'b0;
        else if (start)
            m_run = 1'b1;
        m_en = 1'b1;
    endtask

    task automatic compare_all(input string tag);
        obs_t e;
        for (int i = 0; i < 3; i++) q.push_back(expect_of(i));
        for (int i = 0; i < 3; i++) begin
            e = q.pop_front();
            chk($sformatf("%s_u%0d", tag, i), obs_of(i), e);
        end
    endtask

    task automatic cyc(input bit st = 0, input bit sp = 0, input bit cl = 0, input bit ld = 0,
                       input int lv = 0, input bit ls = 0);
        obs_t e;
        @(negedge clk);
        start = st;
        stop  = sp;
        clear = cl;
        load  = ld;
        if (ld) begin
            load_val  = 4'(lv);
            load_sign = ls;
        end
        model_edge();
        for (int i = 0; i < 3; i++) q.push_back(expect_of(i));
        @(posedge clk);
        #1;
        ncyc++;
        for (int i = 0; i < 3; i++) begin
            e = q.pop_front();
            chk($sformatf("cyc%0d_u%0d", ncyc, i), obs_of(i), e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #2;
        compare_all("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        compare_all("release");
        chk("en_before_edge", en[0], 1'b0);
        cyc();
        chk("en_after_release", en[0], 1'b1);
        chk("point_mask", point[0], MASK);
        cyc(1);
        chk("running_after_start", running[0], 1'b1);
        repeat (13) cyc();
        chk("count_up_3", data[0], 4'd3);
        cyc(0, 0, 0, 1, 9, 1);
        chk("load9_u", data[0], 4'd9);
        chk("load9_sgn_mag", data[2], 4'd9);
        chk("load9_sgn_sign", sign[2], 1'b1);
        chk("load_no_wrap", wrap_p[0], 1'b0);
        repeat (4) cyc();
        chk("wrap_up_data", data[0], 4'd0);
        chk("wrap_up_pulse", wrap_p[0], 1'b1);
        chk("sat_up_data", data[1], 4'd9);
        chk("sat_up_pulse", wrap_p[1], 1'b1);
        chk("sgn_neg9_up", {sign[2], data[2]}, {1'b1, 4'd8});
        cyc();
        chk("wrap_single_pulse", wrap_p[0], 1'b0);
        dir_down = 1'b1;
        cyc(0, 0, 0, 1, 0, 0);
        repeat (8) cyc();
        chk("wrap_down_9_8", data[0], 4'd8);
        chk("sat_down_hold", data[1], 4'd0);
        chk("sgn_down_neg2", {sign[2], data[2]}, {1'b1, 4'd2});
        dir_down = 1'b0;
        cyc(0, 0, 0, 1, 1, 1);
        repeat (12) cyc();
        chk("sgn_up_to_pos2", {sign[2], data[2]}, {1'b0, 4'd2});
        cyc(0, 0, 0, 1, 15, 1);
        chk("load_clamp", data[0], 4'd9);
        for (int k = 0; k < 2 * TD && m_pre != TD - 1; k++) cyc();
        chk("step_phase_found", m_pre, TD - 1);
        cyc(0, 0, 1, 1, 5, 0);
        chk("clear_beats_load", data[0], 4'd0);
        chk("clear_beats_load_sgn", {sign[2], data[2]}, 5'd0);
        repeat (3) cyc();
        chk("no_early_step", data[0], 4'd0);
        cyc();
        chk("step_after_restart", data[0], 4'd1);
        cyc(1, 1);
        chk("start_stop_together", running[0], 1'b0);
        repeat (5) cyc();
        cyc(1);
        repeat (2) cyc();
        cyc(0, 1);
        repeat (6) cyc();
        cyc(1);
        repeat (6) cyc();
        cyc(0, 0, 0, 1, 7, 1);
        repeat (2) cyc();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0;
        model_reset();
        #1;
        compare_all("async_reset");
        chk("async_reset_data", data[0], 4'd0);
        @(posedge clk);
        #1;
        compare_all("reset_held");
        rst_n = 1'b1;
        cyc();
        chk("en_after_second_reset", en[2], 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seg_count_gen.md
Name: seg_count_gen

Overview:
- Parametrised successor to the free-running 0.1 s display counter.
- Generates the value shown on the multi-digit 7-segment display: data, point, en and sign.
- Adds run/pause control, clear, parallel load, up/down counting, signed range, and a selectable wrap or saturate policy.
- Sits between the control/key logic and the segment display driver; that driver consumes data/point/en/sign unchanged.

Parameters:
- TICK_DIV, 2_400_000: sys_clk cycles per count step (0.1 s at 24 MHz); must be >= 2.
- DATA_W, 20: width of data/load_val; must hold MAX_VAL.
- MAX_VAL, 999_999: largest magnitude displayed.
- DIGITS, 6: number of display digits; sets the width of point.
- POINT_MASK, 6'b000000: decimal-point pattern driven on point while en=1 (1 = dot on).
- SIGNED_EN, 0: 1 = range -MAX_VAL..+MAX_VAL in sign-magnitude form; 0 = range 0..MAX_VAL.
- SATURATE, 0: 1 = stop at the range limit; 0 = wrap around.

Ports:
- sys_clk, in, 1: system clock.
- sys_rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: single-cycle pulse; enter RUN.
- stop, in, 1: single-cycle pulse; enter PAUSE.
- clear, in, 1: single-cycle pulse; value := 0, prescaler := 0.
- load, in, 1: single-cycle pulse; value := load_val / load_sign.
- load_val, in, DATA_W: magnitude to load.
- load_sign, in, 1: sign to load; ignored when SIGNED_EN=0.
- dir_down, in, 1: 0 = count up, 1 = count down; sampled at each step.
- data, out, DATA_W: displayed magnitude.
- point, out, DIGITS: decimal-point enables.
- en, out, 1: display enable.
- sign, out, 1: 1 = negative.
- running, out, 1: FSM is in RUN.
- wrap_p, out, 1: one-cycle pulse on wrap or on hitting saturation.

Behaviour:
- Reset (async): data=0, sign=0, point=0, en=0, running=0, wrap_p=0, prescaler=0, FSM=PAUSE.
- First clock after reset release: en=1 and point=POINT_MASK; both stay so until the next reset.
- FSM has two states:
  - PAUSE goes to RUN on start.
  - RUN goes to PAUSE on stop.
  - start and stop together: stop wins.
  - running is registered and equals (state==RUN).
- Prescaler counts 0..TICK_DIV-1, and only in RUN. It holds in PAUSE.
- A step occurs on the edge where prescaler==TICK_DIV-1 in RUN; the prescaler returns to 0 on that edge.
- data/sign are registered and update on the step edge. After start, the first step occurs TICK_DIV cycles later.
- Command priority per cycle: clear > load > step.
  - clear: data=0, sign=0, prescaler=0. FSM state is unchanged.
  - load: data=min(load_val, MAX_VAL), sign=load_sign&SIGNED_EN. If the magnitude is 0, sign is forced to 0. prescaler=0.
- Up step, SIGNED_EN=0:
  - v<MAX_VAL gives v+1.
  - At MAX_VAL: wrap to 0 (SATURATE=0) or hold (SATURATE=1).
- Down step, SIGNED_EN=0:
  - v>0 gives v-1.
  - At 0: wrap to MAX_VAL or hold.
- Signed mode (sign-magnitude):
  - Up on negative: magnitude-1; -1 goes to 0 with sign=0.
  - Up on non-negative: magnitude+1; +MAX_VAL goes to -MAX_VAL (wrap) or holds (saturate).
  - Down mirrors up: 0 goes to -1; -MAX_VAL goes to +MAX_VAL (wrap) or holds.
  - Negative zero never appears.
- wrap_p:
  - Asserted for the single cycle following a wrap step.
  - Under saturation, asserted for the single cycle following any step attempted at the limit.
  - Not asserted by clear or load.
- Reset mid-count: all state is lost immediately; no step pulse is produced.
- Latency: control pulse to output change is 1 cycle. Step edge to wrap_p is 1 cycle.

Decomposition:
- Shared package seg_pkg holds:
  - FSM state encodings ST_PAUSE, ST_RUN;
  - default MAX_VAL/DATA_W constants for the 6-digit board.
- One sub-module, tick_prescaler (params TICK_DIV; ports sys_clk, sys_rst_n, en_i, clr_i, tick_o), generates the step strobe.
- Value/sign update and FSM stay in the top level.

Test Plan (use TICK_DIV=4, MAX_VAL=9, DATA_W=4 unless stated):
- Reset then start, up: data goes 0,1,2,... every 4 cycles. en=1 one cycle after reset release. point=POINT_MASK.
- Wrap, SATURATE=0: load 9, step up gives data=0 and a single wrap_p pulse. Down from 0 gives 9 and a wrap_p pulse.
- SATURATE=1: at 9 stepping up, data stays 9 and wrap_p pulses each step. At 0 stepping down, data stays 0.
- SIGNED_EN=1: load magnitude 1 with load_sign=1, count up gives sign=1/data=1, then sign=0/data=0, then data=1 with sign never 1 at zero. Down from 0 gives sign=1, data=1.
- Same-cycle collisions:
  - clear and load together on a step cycle: data=0, prescaler restarts, next step 4 cycles later.
  - start and stop together: running=0.
- stop in RUN freezes data and prescaler. start resumes, and the next step arrives after the remaining prescaler count. Async reset asserted mid-count: all outputs 0 immediately.
